// File: rtl/sequenciador_medicao_if.sv
// Signal bundle between the measurement sequencer and its sensor front-end/discretizer side.
interface sequenciador_medicao_if;
  logic       habilita;
  logic       pronto;
  logic [1:0] categoria;
  logic       medir;
  logic       load_disc;
  logic [1:0] categoria_estavel;
  logic       nova_categoria;
  logic       falha;
  logic [3:0] contagem_falhas;
  logic       ocupado;

  modport master (
    input  habilita, pronto, categoria,
    output medir, load_disc, categoria_estavel, nova_categoria, falha, contagem_falhas, ocupado
  );

  modport slave (
    output habilita, pronto, categoria,
    input  medir, load_disc, categoria_estavel, nova_categoria, falha, contagem_falhas, ocupado
  );
endinterface

// File: rtl/sequenciador_medicao.sv
// Periodic measurement sequencer: triggers the sensor, waits for completion with a timeout,
// loads the discretizer and debounces the resulting category.
module sequenciador_medicao #(
  parameter int unsigned INTERVALO = 50000000,
  parameter int unsigned TIMEOUT   = 2500000,
  parameter int unsigned CONFIRMA  = 3
) (
  input logic                   clk,
  input logic                   reset,
  sequenciador_medicao_if.master bus
);

  localparam int unsigned WI = $clog2(INTERVALO);
  localparam int unsigned WT = $clog2(TIMEOUT);
  localparam logic [WI-1:0] INT_FIM  = WI'(INTERVALO - 1);
  localparam logic [WT-1:0] TO_FIM   = WT'(TIMEOUT - 1);
  localparam logic [2:0]    CONF_MAX = 3'(CONFIRMA);

  typedef enum logic [2:0] {StOcioso, StDispara, StEspera, StCarrega, StAvalia} estado_t;

  estado_t       estado_q, estado_d;
  logic [WI-1:0] cnt_int_q, cnt_int_d;
  logic [WT-1:0] cnt_to_q, cnt_to_d;
  logic [1:0]    cand_q, cand_d;
  logic [2:0]    conf_q, conf_d, conf_nova;
  logic          medir_q, medir_d;
  logic          load_q, load_d;
  logic [1:0]    estavel_q, estavel_d;
  logic          nova_q, nova_d;
  logic          falha_q, falha_d;
  logic [3:0]    falhas_q, falhas_d;
  logic          ocupado_q, ocupado_d;

  always_comb begin
    estado_d  = estado_q;
    cnt_int_d = cnt_int_q;
    cnt_to_d  = cnt_to_q;
    cand_d    = cand_q;
    conf_d    = conf_q;
    conf_nova = conf_q;
    medir_d   = 1'b0;
    load_d    = 1'b0;
    estavel_d = estavel_q;
    nova_d    = 1'b0;
    falha_d   = falha_q;
    falhas_d  = falhas_q;

    unique case (estado_q)
      StOcioso: begin
        if (!bus.habilita) begin
          cnt_int_d = '0;
        end else if (cnt_int_q == INT_FIM) begin
          estado_d  = StDispara;
          cnt_int_d = '0;
          medir_d   = 1'b1;
        end else begin
          cnt_int_d = cnt_int_q + 1'b1;
        end
      end
      StDispara: begin
        estado_d = StEspera;
        cnt_to_d = '0;
      end
      StEspera: begin
        // pronto wins over a simultaneous timeout
        if (bus.pronto) begin
          estado_d = StCarrega;
          load_d   = 1'b1;
        end else if (cnt_to_q == TO_FIM) begin
          estado_d = StOcioso;
          falha_d  = 1'b1;
          conf_d   = '0;
          if (falhas_q != 4'hf) falhas_d = falhas_q + 1'b1;
        end else begin
          cnt_to_d = cnt_to_q + 1'b1;
        end
      end
      StCarrega: begin
        estado_d = StAvalia;
      end
      StAvalia: begin
        if (bus.categoria == cand_q) begin
          conf_nova = (conf_q == CONF_MAX) ? conf_q : conf_q + 3'd1;
        end else begin
          cand_d    = bus.categoria;
          conf_nova = 3'd1;
        end
        conf_d = conf_nova;
        if (conf_nova == CONF_MAX && bus.categoria != estavel_q) begin
          estavel_d = bus.categoria;
          nova_d    = 1'b1;
        end
        falha_d   = 1'b0;
        cnt_int_d = '0;
        estado_d  = StOcioso;
      end
      default: begin
        estado_d = StOcioso;
      end
    endcase

    ocupado_d = (estado_d != StOcioso);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q  <= StOcioso;
      cnt_int_q <= '0;
      cnt_to_q  <= '0;
      cand_q    <= '0;
      conf_q    <= '0;
      medir_q   <= 1'b0;
      load_q    <= 1'b0;
      estavel_q <= '0;
      nova_q    <= 1'b0;
      falha_q   <= 1'b0;
      falhas_q  <= '0;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_int_q <= cnt_int_d;
      cnt_to_q  <= cnt_to_d;
      cand_q    <= cand_d;
      conf_q    <= conf_d;
      medir_q   <= medir_d;
      load_q    <= load_d;
      estavel_q <= estavel_d;
      nova_q    <= nova_d;
      falha_q   <= falha_d;
      falhas_q  <= falhas_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign bus.medir             = medir_q;
  assign bus.load_disc         = load_q;
  assign bus.categoria_estavel = estavel_q;
  assign bus.nova_categoria    = nova_q;
  assign bus.falha             = falha_q;
  assign bus.contagem_falhas   = falhas_q;
  assign bus.ocupado           = ocupado_q;

endmodule

// File: tb/tb_sequenciador_medicao.sv
// Bench for sequenciador_medicao: directed scenarios plus random stimulus, checked every cycle
// against a step-count model of a measurement and a history-based debounce model.
module tb_sequenciador_medicao;

  localparam int unsigned INTERVALO = 10;
  localparam int unsigned TIMEOUT   = 20;
  localparam int unsigned CONFIRMA  = 3;

  logic clk;
  logic reset;
  sequenciador_medicao_if bus ();

  sequenciador_medicao #(
    .INTERVALO(INTERVALO),
    .TIMEOUT  (TIMEOUT),
    .CONFIRMA (CONFIRMA)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errs;
  int checks;

  // Model: a measurement is described by the step count since its trigger (step 0 = medir)
  // and the step at which pronto was accepted; debounce by the list of recent results.
  bit m_busy;
  int m_s, m_p, m_run;
  int m_hist[$];
  int m_est, m_cf;
  bit m_medir, m_load, m_nova, m_falha;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_s = 0; m_p = -1; m_run = 0;
    m_hist.delete();
    m_est = 0; m_cf = 0;
    m_medir = 0; m_load = 0; m_nova = 0; m_falha = 0;
  endtask

  task automatic model_result(input int c);
    bit iguais;
    m_hist.push_back(c);
    if (m_hist.size() > CONFIRMA) void'(m_hist.pop_front());
    iguais = (m_hist.size() == CONFIRMA);
    foreach (m_hist[i]) if (m_hist[i] != c) iguais = 0;
    if (iguais && c != m_est) begin
      m_est  = c;
      m_nova = 1;
    end
  endtask

  // One clock edge of the model, using the inputs that were present at that edge.
  task automatic model_step(input bit h, input bit p, input int c);
    m_medir = 0; m_load = 0; m_nova = 0;
    if (!m_busy) begin
      m_run = h ? m_run + 1 : 0;
      if (m_run == INTERVALO) begin
        m_busy = 1; m_s = 0; m_p = -1; m_run = 0; m_medir = 1;
      end
    end else begin
      if (m_p < 0 && m_s >= 1 && m_s <= TIMEOUT && p) m_p = m_s;
      m_s++;
      if (m_p >= 0) begin
        if (m_s == m_p + 1) m_load = 1;
        if (m_s == m_p + 3) begin
          model_result(c);
          m_falha = 0;
          m_busy  = 0;
        end
      end else if (m_s == TIMEOUT + 1) begin
        m_falha = 1;
        if (m_cf < 15) m_cf++;
        m_hist.delete();
        m_busy = 0;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    if (!reset) model_step(bus.habilita, bus.pronto, int'(bus.categoria));
    chk("medir", int'(bus.medir), int'(m_medir));
    chk("load_disc", int'(bus.load_disc), int'(m_load));
    chk("ocupado", int'(bus.ocupado), int'(m_busy));
    chk("categoria_estavel", int'(bus.categoria_estavel), m_est);
    chk("nova_categoria", int'(bus.nova_categoria), int'(m_nova));
    chk("falha", int'(bus.falha), int'(m_falha));
    chk("contagem_falhas", int'(bus.contagem_falhas), m_cf);
  endtask

  task automatic wait_medir(output int n);
    n = 0;
    while (!bus.medir && n < 100) begin
      cycle();
      n++;
    end
    if (!bus.medir) chk("wait_medir_bound", int'(bus.medir), 1);
  endtask

  // d > 0: pronto accepted d steps after medir; d == 0: no pronto (timeout).
  task automatic meas(input int d, input logic [1:0] c);
    int n;
    bus.categoria = c;
    wait_medir(n);
    if (d > 0) begin
      repeat (d) cycle();
      bus.pronto = 1'b1;
      cycle();
      chk("load_after_pronto", int'(bus.load_disc), 1);
      bus.pronto = 1'b0;
      cycle();
      cycle();
    end else begin
      repeat (TIMEOUT + 1) cycle();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int cnt;
    logic [1:0] seq_cat [6];
    int         seq_nova [6];
    errs = 0;
    checks = 0;
    reset = 1'b1;
    bus.habilita  = 1'b0;
    bus.pronto    = 1'b0;
    bus.categoria = 2'd0;
    model_reset();

    // Reset state
    cycle();
    chk("reset_ocupado", int'(bus.ocupado), 0);
    chk("reset_contagem", int'(bus.contagem_falhas), 0);

    // First measurement: medir 10 cycles after habilita, pronto 5 steps later
    reset = 1'b0;
    bus.habilita = 1'b1;
    wait_medir(n);
    chk("first_medir_latency", n, 10);
    bus.categoria = 2'd2;
    repeat (5) cycle();
    bus.pronto = 1'b1;
    cycle();
    chk("load_1_after_pronto", int'(bus.load_disc), 1);
    bus.pronto = 1'b0;
    cycle();
    cycle();
    chk("estavel_after_one", int'(bus.categoria_estavel), 0);

    // Two more 2s confirm the category
    meas(3, 2'd2);
    chk("nova_after_two", int'(bus.nova_categoria), 0);
    meas(7, 2'd2);
    chk("nova_after_three", int'(bus.nova_categoria), 1);
    chk("estavel_after_three", int'(bus.categoria_estavel), 2);
    cycle();
    chk("nova_single_pulse", int'(bus.nova_categoria), 0);

    // 2,2,1,2,2,2 from reset: change only after three consecutive 2s
    do_reset();
    seq_cat  = '{2'd2, 2'd2, 2'd1, 2'd2, 2'd2, 2'd2};
    seq_nova = '{0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 6; i++) begin
      meas(2 + i, seq_cat[i]);
      chk("seq_nova", int'(bus.nova_categoria), seq_nova[i]);
    end
    chk("seq_estavel", int'(bus.categoria_estavel), 2);

    // Timeout, recovery, saturation
    meas(0, 2'd1);
    chk("timeout_falha", int'(bus.falha), 1);
    chk("timeout_contagem", int'(bus.contagem_falhas), 1);
    meas(4, 2'd1);
    chk("recover_falha", int'(bus.falha), 0);
    chk("recover_contagem", int'(bus.contagem_falhas), 1);
    for (int i = 0; i < 16; i++) meas(0, 2'd1);
    chk("contagem_saturada", int'(bus.contagem_falhas), 15);

    // pronto on the exact timeout step
    meas(TIMEOUT, 2'd3);
    chk("edge_timeout_falha", int'(bus.falha), 0);

    // pronto while idle is ignored
    bus.habilita = 1'b0;
    bus.pronto = 1'b1;
    repeat (15) cycle();
    chk("idle_pronto_load", int'(bus.load_disc), 0);
    chk("idle_pronto_ocupado", int'(bus.ocupado), 0);
    bus.pronto = 1'b0;

    // Reset in the middle of ESPERA
    bus.habilita = 1'b1;
    wait_medir(n);
    repeat (3) cycle();
    reset = 1'b1;
    model_reset();
    cycle();
    chk("rst_mid_ocupado", int'(bus.ocupado), 0);
    chk("rst_mid_estavel", int'(bus.categoria_estavel), 0);
    chk("rst_mid_contagem", int'(bus.contagem_falhas), 0);
    reset = 1'b0;

    // habilita dropped during ESPERA: sequence completes, then no further trigger
    wait_medir(n);
    bus.habilita = 1'b0;
    repeat (4) cycle();
    bus.pronto = 1'b1;
    cycle();
    chk("hab_drop_load", int'(bus.load_disc), 1);
    bus.pronto = 1'b0;
    cnt = 0;
    repeat (40) begin
      cycle();
      if (bus.medir) cnt++;
    end
    chk("hab_drop_no_medir", cnt, 0);
    chk("hab_drop_idle", int'(bus.ocupado), 0);

    // Random stimulus
    for (int i = 0; i < 4000; i++) begin
      cycle();
      bus.habilita = ($urandom_range(0, 9) != 0);
      bus.pronto   = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 5) == 0) bus.categoria = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 399) == 0) begin
        reset = 1'b1;
        model_reset();
      end else begin
        reset = 1'b0;
      end
    end
    reset = 1'b0;
    cycle();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/sequenciador_medicao.md
SEQUENCIADOR_MEDICAO -- requirements
Module: sequenciador_medicao

Interface
REQ-001 SHALL have parameter INTERVALO, default 50000000: clk cycles from returning to OCIOSO until the next measurement trigger (minimum 2).
REQ-002 SHALL have parameter TIMEOUT, default 2500000: maximum clk cycles spent in ESPERA waiting for pronto (minimum 2).
REQ-003 SHALL have parameter CONFIRMA, default 3: consecutive identical categories required before the stable category changes (range 1..7).
REQ-004 SHALL have port clk, input, 1 bit: clock, rising edge.
REQ-005 SHALL have port reset, input, 1 bit: asynchronous, active-high.
REQ-006 SHALL have port habilita, input, 1 bit: enables periodic measurement.
REQ-007 SHALL have port pronto, input, 1 bit: sensor front-end measurement-complete pulse.
REQ-008 SHALL have port categoria, input, 2 bits: registered discretizer output.
REQ-009 SHALL have port medir, output, 1 bit: one-cycle trigger to the sensor front-end.
REQ-010 SHALL have port load_disc, output, 1 bit: one-cycle load strobe to the discretizer.
REQ-011 SHALL have port categoria_estavel, output, 2 bits: confirmed category.
REQ-012 SHALL have port nova_categoria, output, 1 bit: one-cycle pulse when categoria_estavel changes.
REQ-013 SHALL have port falha, output, 1 bit: last measurement timed out.
REQ-014 SHALL have port contagem_falhas, output, 4 bits: saturating timeout count.
REQ-015 SHALL have port ocupado, output, 1 bit: high in every state except OCIOSO.

Function
REQ-016 SHALL implement states OCIOSO, DISPARA, ESPERA, CARREGA, AVALIA; all outputs registered.
REQ-017 OCIOSO: interval counter SHALL increment while habilita=1 and hold at 0 while habilita=0; at count INTERVALO-1 with habilita=1 SHALL go to DISPARA and clear the counter.
REQ-018 DISPARA SHALL last exactly one cycle with medir=1, then go to ESPERA with timeout counter 0.
REQ-019 ESPERA: pronto=1 SHALL go to CARREGA; otherwise at timeout count TIMEOUT-1 SHALL go to OCIOSO, set falha=1, increment contagem_falhas saturating at 15, and clear the confirmation counter.
REQ-020 pronto and timeout in the same cycle SHALL be treated as pronto (no failure).
REQ-021 pronto outside ESPERA SHALL be ignored.
REQ-022 CARREGA SHALL last one cycle with load_disc=1, then go to AVALIA; categoria SHALL be sampled in AVALIA, one cycle after load_disc.
REQ-023 AVALIA, same-category case: when categoria equals the candidate register, the confirmation counter SHALL increment, saturating at CONFIRMA.
REQ-024 AVALIA, new-category case: otherwise candidate SHALL take categoria and the counter SHALL become 1.
REQ-025 AVALIA stable update: if the post-update counter equals CONFIRMA and categoria differs from categoria_estavel, categoria_estavel SHALL take categoria and nova_categoria SHALL pulse one cycle, asserted in the cycle after AVALIA.
REQ-026 AVALIA SHALL clear falha (contagem_falhas unchanged) and return to OCIOSO with the interval counter at 0.
REQ-027 habilita dropping mid-measurement SHALL NOT abort the measurement; the sequence completes, then the block stays in OCIOSO.
REQ-028 End-to-end latency from pronto to load_disc SHALL be 1 cycle.

Reset
REQ-029 Reset SHALL force state OCIOSO and all counters to 0.
REQ-030 Reset SHALL force the candidate register to 0, and SHALL force medir=0, load_disc=0, categoria_estavel=0, nova_categoria=0, falha=0, contagem_falhas=0 and ocupado=0.
REQ-031 Reset asserted mid-measurement SHALL abandon it with no load_disc issued.

Verification (bench parameters INTERVALO=10, TIMEOUT=20, CONFIRMA=3)
REQ-032 habilita=1 from reset; pronto 5 cycles after medir with categoria=2 -> medir 10 cycles after habilita, load_disc 1 cycle after pronto, categoria_estavel stays 0.
REQ-033 Three consecutive measurements with categoria=2 -> nova_categoria single pulse after the third AVALIA, categoria_estavel=2.
REQ-034 Sequence 2,2,1,2,2 -> no change on the third or fourth result; the change is deferred until three consecutive 2s.
REQ-035 No pronto for 20 cycles in ESPERA -> falha=1, contagem_falhas=1, no load_disc; a subsequent good measurement clears falha and contagem_falhas stays 1; 17 timeouts -> contagem_falhas=15.
REQ-036 pronto on the exact timeout cycle -> load_disc asserted, falha=0; pronto while in OCIOSO -> ignored.
REQ-037 Reset pulsed during ESPERA -> all outputs 0 next cycle, no load_disc; habilita dropped in ESPERA -> sequence completes, then no further medir.
